// File: rtl/rpxx_seek.sv
// RPxx head-positioning engine: steps the current cylinder toward the latched
// desired cylinder with per-step and settle timing, and reports PIP/DONE/IAE.
module rpxx_seek #(
  parameter int CYLMAX      = 814,
  parameter int STEP_CLKS   = 100,
  parameter int SETTLE_CLKS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rpDC,
  input  logic        rpSEEK,
  input  logic        rpRECAL,
  input  logic        rpPRESET,
  input  logic        rpCLR,
  output logic [15:0] rpCC,
  output logic        rpPIP,
  output logic        rpDONE,
  output logic        rpIAE
);

  localparam int CNT_MAX = (STEP_CLKS > SETTLE_CLKS) ? STEP_CLKS : SETTLE_CLKS;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] STEP_LOAD   = CW'(STEP_CLKS - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CLKS - 1);
  localparam logic [10:0]   CYL_LIM     = 11'(CYLMAX);

  typedef enum logic [2:0] {IDLE, CHECK, STEP, SETTLE, DONE} state_t;

  state_t        state_reg, state_next;
  logic [9:0]    target_reg, target_next;
  logic [9:0]    cyl_reg, cyl_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          iae_reg, iae_next;
  logic          done_reg, done_next;

  // Only the 10-bit cylinder field of the desired-cylinder register matters.
  logic unused_dc;
  assign unused_dc = ^rpDC[15:10];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      target_reg <= '0;
      cyl_reg    <= '0;
      cnt_reg    <= '0;
      iae_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
      cyl_reg    <= cyl_next;
      cnt_reg    <= cnt_next;
      iae_reg    <= iae_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    cyl_next    = cyl_reg;
    cnt_next    = cnt_reg;
    iae_next    = iae_reg;
    // DONE is reported one clock after the DONE state, as a registered pulse.
    done_next   = (state_reg == DONE);

    // Clear comes first so an error detected in CHECK overrides it.
    if (rpCLR) iae_next = 1'b0;

    if (rpRECAL || rpPRESET) begin
      target_next = '0;
      cnt_next    = '0;
      state_next  = CHECK;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rpSEEK) begin
            target_next = rpDC[9:0];
            state_next  = CHECK;
          end
        end
        CHECK: begin
          if ({1'b0, target_reg} > CYL_LIM) begin
            iae_next   = 1'b1;
            state_next = DONE;
          end else if (target_reg == cyl_reg) begin
            cnt_next   = SETTLE_LOAD;
            state_next = SETTLE;
          end else begin
            cnt_next   = STEP_LOAD;
            state_next = STEP;
          end
        end
        STEP: begin
          if (cnt_reg == '0) begin
            cyl_next = (target_reg > cyl_reg) ? cyl_reg + 10'd1 : cyl_reg - 10'd1;
            if (cyl_next == target_reg) begin
              cnt_next   = SETTLE_LOAD;
              state_next = SETTLE;
            end else begin
              cnt_next = STEP_LOAD;
            end
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_reg == '0) state_next = DONE;
          else               cnt_next   = cnt_reg - 1'b1;
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign rpCC   = {6'b0, cyl_reg};
  assign rpPIP  = (state_reg == CHECK) || (state_reg == STEP) || (state_reg == SETTLE);
  assign rpDONE = done_reg;
  assign rpIAE  = iae_reg;

endmodule

// File: tb/tb_rpxx_seek.sv
// Scoreboard bench for rpxx_seek: stimulus pushes expected completions, a
// monitor checks every cycle against a timing model of the positioning rules.
module tb_rpxx_seek;
  localparam int CYLMAX = 814;
  localparam int STEP   = 4;
  localparam int SETTLE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rpDC = '0;
  logic        rpSEEK = 1'b0, rpRECAL = 1'b0, rpPRESET = 1'b0, rpCLR = 1'b0;
  logic [15:0] rpCC;
  logic        rpPIP, rpDONE, rpIAE;

  rpxx_seek #(.CYLMAX(CYLMAX), .STEP_CLKS(STEP), .SETTLE_CLKS(SETTLE)) dut (
    .clk(clk), .rst(rst), .rpDC(rpDC), .rpSEEK(rpSEEK), .rpRECAL(rpRECAL),
    .rpPRESET(rpPRESET), .rpCLR(rpCLR), .rpCC(rpCC), .rpPIP(rpPIP),
    .rpDONE(rpDONE), .rpIAE(rpIAE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int done_cyc; int cc; bit err;} exp_t;
  exp_t sb[$];
  exp_t e;

  // Model of the current operation: issue = cycle of the negedge that drove it.
  int op_issue = 0, op_lat = 0, op_start = 0, op_target = 0;
  bit op_live = 1'b0, op_err = 1'b0, exp_iae = 1'b0;
  int total = 0, bad = 0;

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int exp_cc_at(int c);
    int d, n, steps;
    if (!op_live || op_err) return op_start;
    d = c - op_issue - 1;
    if (d < 1) return op_start;
    n = iabs(op_target - op_start);
    steps = (d - 1) / STEP;
    if (steps > n) steps = n;
    return (op_target >= op_start) ? op_start + steps : op_start - steps;
  endfunction

  function automatic bit busy(int c);
    return op_live && (c < op_issue + op_lat + 1);
  endfunction

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic new_op(int tgt);
    int i = cyc;
    int st = exp_cc_at(i);
    while (sb.size() > 0 && sb[sb.size()-1].done_cyc > i + 1) void'(sb.pop_back());
    op_start  = st;
    op_target = tgt;
    op_err    = (tgt > CYLMAX);
    op_issue  = i;
    op_lat    = op_err ? 2 : 2 + iabs(tgt - st) * STEP + SETTLE;
    op_live   = 1'b1;
    sb.push_back('{i + 1 + op_lat, op_err ? st : tgt, op_err});
  endtask

  task automatic do_seek(logic [15:0] dc);
    @(negedge clk);
    rpDC = dc;
    rpSEEK = 1'b1;
    if (!busy(cyc)) new_op(int'(dc[9:0]));
    @(negedge clk);
    rpSEEK = 1'b0;
  endtask

  task automatic do_recal(bit pre, bit with_seek);
    @(negedge clk);
    rpRECAL  = !pre;
    rpPRESET = pre;
    rpSEEK   = with_seek;
    rpDC     = 16'($urandom);
    new_op(0);
    @(negedge clk);
    rpRECAL = 1'b0; rpPRESET = 1'b0; rpSEEK = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    rpCLR = 1'b1;
    exp_iae = 1'b0;
    @(negedge clk);
    rpCLR = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    op_live = 1'b0; op_start = 0; op_err = 1'b0; exp_iae = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL idle_timeout: %0d completions still pending, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: completion scoreboard plus per-cycle cylinder/PIP/IAE checks.
  initial forever begin
    @(posedge clk);
    #2;
    if (!rst) begin
      if (rpDONE) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: rpDONE=1, expected 0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("done_cc", int'(rpCC), e.cc);
          if (e.err) exp_iae = 1'b1;
          check("done_iae", int'(rpIAE), int'(exp_iae));
        end
      end else if (sb.size() != 0 && cyc >= sb[0].done_cyc) begin
        total++; bad++;
        $display("FAIL done_missing: rpDONE=0, expected 1 at cycle %0d", sb[0].done_cyc);
        void'(sb.pop_front());
      end
      check("cc", int'(rpCC), exp_cc_at(cyc));
      check("pip", int'(rpPIP),
            int'(op_live && cyc >= op_issue + 1 && cyc <= op_issue + op_lat - 1));
      if (!(op_live && op_err && cyc < op_issue + op_lat + 1))
        check("iae", int'(rpIAE), int'(exp_iae));
    end
  end

  initial begin
    int cur, tgt, r, ev;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_seek(16'd3);        wait_idle();   // 0 -> 3
    do_seek(16'h0403);     wait_idle();   // upper bits ignored, no motion
    do_seek(16'd815);      wait_idle();   // illegal target
    do_clr();              repeat (2) @(negedge clk);
    do_seek(16'd10);       wait_idle();
    do_seek(16'd20);                      // recal right after the 3rd step
    while (cyc < op_issue + 13) @(negedge clk);
    do_recal(1'b0, 1'b0);  wait_idle();
    do_seek(16'd6);                       // re-seek while busy is ignored
    repeat (5) @(negedge clk);
    do_seek(16'd2);        wait_idle();
    do_seek(16'd5);                       // reset mid-step
    repeat (7) @(negedge clk);
    do_reset();            repeat (2) @(negedge clk);
    do_seek(16'd3);        wait_idle();
    do_seek(16'd9);
    do_recal(1'b1, 1'b1);  wait_idle();   // preset wins over simultaneous seek

    for (int k = 0; k < 50; k++) begin
      cur = exp_cc_at(cyc);
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        tgt = cur + int'($urandom_range(0, 24)) - 12;
        if (tgt < 0) tgt = 0;
      end else if (r < 9) tgt = int'($urandom_range(0, 1023));
      else tgt = int'($urandom_range(815, 1023));
      do_seek({6'($urandom), 10'(tgt)});
      ev = int'($urandom_range(0, 5));
      if (ev == 0) begin
        repeat ($urandom_range(0, op_lat)) @(negedge clk);
        do_seek(16'($urandom));
      end else if (ev == 1 && !op_err) begin
        repeat ($urandom_range(0, op_lat - 1)) @(negedge clk);
        do_recal(1'($urandom), 1'($urandom));
      end else if (ev == 2 && !op_err) begin
        repeat ($urandom_range(0, op_lat - 3)) @(negedge clk);
        do_clr();
      end
      wait_idle();
      if (ev == 3) do_clr();
    end

    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
